// File: rtl/fp_requant_if.sv
// fp_requant_if: input and output valid/ready streams of the requantizer
interface fp_requant_if #(
  parameter int IW = 28,
  parameter int OW = 14
);
  logic [IW-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [OW-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_sat;
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid, out_sat);
  modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid, out_sat);
endinterface

// File: rtl/fp_requant.sv
// fp_requant: two-stage round/shift then saturate of a signed fixed-point product; FP_REQUANT_ROUND_EN selects round-half-up instead of floor
module fp_requant #(
  parameter int IN_INT = 12,
  parameter int IN_FRAC = 16,
  parameter int OUT_INT = 6,
  parameter int OUT_FRAC = 8
) (
  input logic clk,
  input logic reset,
  fp_requant_if.slave s,
  input logic clear_count,
  output logic [15:0] sat_count
);
  localparam int IW = IN_INT + IN_FRAC;
  localparam int OW = OUT_INT + OUT_FRAC;
  localparam int D = IN_FRAC - OUT_FRAC;
`ifdef FP_REQUANT_ROUND_EN
  localparam logic signed [IW:0] HALF = (IW+1)'((2 ** D) / 2);
`else
  localparam logic signed [IW:0] HALF = '0;
`endif
  localparam logic signed [IW:0] RMAX = (IW+1)'((2 ** (OW - 1)) - 1);
  localparam logic signed [IW:0] RMIN = ~RMAX;
  logic signed [IW:0] x, r1_d, r1_q;
  logic v1_d, v1_q, ov_d, ov_q, os_d, os_q, en1, en2, hi, lo;
  logic [OW-1:0] od_d, od_q;
  logic [15:0] cnt_d, cnt_q;
  // stage enables, round/shift into S1, clamp into S2, saturating event counter
  always_comb begin
    en2 = !ov_q | s.out_ready;
    en1 = !v1_q | en2;
    x = {s.in_data[IW-1], s.in_data};
    v1_d = en1 ? s.in_valid : v1_q;
    r1_d = (en1 & s.in_valid) ? (x + HALF) >>> D : r1_q;
    hi = r1_q > RMAX;
    lo = r1_q < RMIN;
    ov_d = en2 ? v1_q : ov_q;
    os_d = en2 ? hi | lo : os_q;
    od_d = en2 ? (hi ? RMAX[OW-1:0] : lo ? RMIN[OW-1:0] : r1_q[OW-1:0]) : od_q;
    cnt_d = clear_count ? '0 : (ov_q & s.out_ready & os_q & ~&cnt_q) ? cnt_q + 16'd1 : cnt_q;
  end
  // pipeline and counter registers; reset drops every in-flight sample
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0;
      r1_q <= '0;
      ov_q <= 1'b0;
      os_q <= 1'b0;
      od_q <= '0;
      cnt_q <= '0;
    end else begin
      v1_q <= v1_d;
      r1_q <= r1_d;
      ov_q <= ov_d;
      os_q <= os_d;
      od_q <= od_d;
      cnt_q <= cnt_d;
    end
  end
  assign s.in_ready = en1 & !reset;
  assign s.out_data = od_q;
  assign s.out_valid = ov_q;
  assign s.out_sat = os_q;
  assign sat_count = cnt_q;
endmodule

// File: doc/fp_requant.md
# fp_requant

Pipelined fixed-point requantizer that sits directly downstream of the fixed-point multiplier. It takes the full-width signed product (IN_INT integer, IN_FRAC fractional bits) and reduces it to a narrower signed Q(OUT_INT).(OUT_FRAC) word by rounding the fraction and saturating the integer part. It uses a valid/ready stream interface, sustains one sample per cycle, and counts saturation events for debug.

## Interface
- IN_INT, default 12: integer bits of input (int1+int2 of the multiplier).
- IN_FRAC, default 16: fractional bits of input.
- OUT_INT, default 6: integer bits of output; 1 ≤ OUT_INT ≤ IN_INT.
- OUT_FRAC, default 8: fractional bits of output; 0 ≤ OUT_FRAC ≤ IN_FRAC.
- Derived: IW = IN_INT+IN_FRAC, OW = OUT_INT+OUT_FRAC, D = IN_FRAC−OUT_FRAC.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_data  in  IW  signed product.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  OW  signed requantized sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts out_data.
- out_sat  out  1  current out_data was clamped; qualified by out_valid.
- clear_count  in  1  synchronous clear of sat_count.
- sat_count  out  16  number of saturated samples delivered.

## Operation
- Two register stages: S1 (round/shift), S2 (saturate). Each stage has a valid bit v1/v2.
- Stage enables: en2 = !v2 | out_ready; en1 = !v1 | en2; in_ready = en1 & !reset.
- Input handshake: in_valid & in_ready loads S1; v1 <= in_valid when en1.
- S1 arithmetic, on an (IW+1)-bit sign-extended value x:
  - D = 0: r = x.
  - D > 0, rounding enabled: r = (x + 2^(D−1)) >>> D (round half up, toward +inf on ties).
  - D > 0, rounding disabled: r = x >>> D (floor).
- S2 arithmetic: MAX = 2^(OW−1)−1, MIN = −2^(OW−1). r > MAX → out_data = MAX, out_sat = 1; r < MIN → out_data = MIN, out_sat = 1; else out_data = r[OW−1:0], out_sat = 0.
- S2 loads from S1 when en2; v2 <= v1.
- Output holds out_data/out_sat/out_valid stable while out_valid & !out_ready. No bubbles are inserted.
- sat_count increments by 1 on each output handshake (out_valid & out_ready & out_sat). It saturates at 0xFFFF and does not wrap. clear_count forces 0. If clear_count and an increment occur in the same cycle, clear wins and the result is 0.

## Timing
- Latency: 2 cycles from the input handshake to out_valid, with out_ready held high.
- Throughput: 1 sample/cycle.
- in_ready is a combinational function of out_ready and the valid bits. There is no combinational in_data→out_data path.
- Reset values: out_data = 0, out_valid = 0, out_sat = 0, sat_count = 0, v1 = 0, S1 data = 0. in_ready = 0 while reset is high and 1 in the first cycle after.
- Reset asserted mid-stream discards every in-flight sample. No partial output is produced.
- Backpressure: with out_ready low and both stages full, in_ready = 0. When out_ready rises, both stages advance in the same cycle.

## Configuration
- FP_REQUANT_ROUND_EN defined: S1 applies round-half-up as above.
- FP_REQUANT_ROUND_EN undefined: S1 truncates (arithmetic shift, floor). Saturation and the handshake are identical in both builds.

## Test plan
All scenarios use defaults (Q12.16 → Q6.8, D = 8, out range 0x2000..0x1FFF).
1. in_data = 0x0018000 (1.5), out_ready = 1 → two cycles later out_data = 0x0180, out_sat = 0, sat_count unchanged.
2. Rounding:
   - in_data = 384 raw → ROUND_EN: out_data = 2; no macro: out_data = 1.
   - in_data = −384 raw → ROUND_EN: out_data = −1 (0x3FFF); no macro: out_data = −2 (0x3FFE).
3. Saturation: in_data = 40.0 (40·2^16) → out_data = 0x1FFF, out_sat = 1. in_data = −40.0 → out_data = 0x2000, out_sat = 1. sat_count = 2 after both handshakes.
4. Backpressure: stream 5 consecutive values with out_ready low for cycles 3–6 → in_ready drops once both stages are full. All 5 outputs appear in order with no loss or duplication, and out_data stays stable while stalled.
5. Counter: preload sat_count to 0xFFFF via 65535 saturating samples, send one more saturating sample → count stays 0xFFFF. Pulse clear_count in the same cycle as a saturating handshake → count = 0.
6. Reset mid-stream: assert reset with v1 = v2 = 1 for one cycle → out_valid = 0 and out_data = 0 next cycle. No stale sample ever appears, and sat_count = 0.
